iter_multiplier: RTL and testbench



---
 rtl/iter_multiplier.sv | 117 +++++++++++
 tb/tb_iter_multiplier.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/iter_multiplier.sv
// Multi-cycle radix-2 shift-add multiplier; signed_i selects two's-complement operands.
// Optional build macro EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
module iter_multiplier #(
  parameter int size = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic [size-1:0] src1_i,
  input  logic [size-1:0] src2_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [size-1:0] result_lo_o,
  output logic [size-1:0] result_hi_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = $clog2(size + 1);
  localparam logic [CW-1:0]     LAST  = CW'(size);
  localparam logic [CW-1:0]     ONE_C = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [size-1:0]   ONE_S = {{(size-1){1'b0}}, 1'b1};
  localparam logic [2*size-1:0] ONE_P = {{(2*size-1){1'b0}}, 1'b1};

  // Handshake: start_i is honoured only while IDLE (busy_o low); done_o is a
  // single-cycle pulse and the result registers hold until the next done_o.
  logic [1:0]        state_q, state_d;
  logic [2*size-1:0] mcand_q, mcand_d;
  logic [size-1:0]   mplier_q, mplier_d;
  logic [2*size-1:0] acc_q, acc_d;
  logic [CW-1:0]     count_q, count_d;
  logic              neg_q, neg_d;
  logic [2*size-1:0] res_q, res_d;

  logic [size-1:0]   abs1, abs2, mplier_nxt;
  logic [2*size-1:0] sum, prod;
  logic [CW-1:0]     count_inc;
  logic              last_step;

  // The most-negative operand negates to itself, which is its correct unsigned magnitude.
  assign abs1 = (signed_i && src1_i[size-1]) ? (~src1_i + ONE_S) : src1_i;
  assign abs2 = (signed_i && src2_i[size-1]) ? (~src2_i + ONE_S) : src2_i;

  assign sum        = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign prod       = neg_q ? (~sum + ONE_P) : sum;
  assign count_inc  = count_q + ONE_C;
  assign mplier_nxt = mplier_q >> 1;

`ifdef EARLY_TERM_EN
  assign last_step = (count_inc == LAST) || (mplier_nxt == '0);
`else
  assign last_step = (count_inc == LAST);
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    neg_d    = neg_q;
    res_d    = res_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mcand_d  = {{size{1'b0}}, abs1};
          mplier_d = abs2;
          neg_d    = signed_i & (src1_i[size-1] ^ src2_i[size-1]);
          acc_d    = '0;
          count_d  = '0;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_nxt;
        count_d  = count_inc;
        if (last_step) begin
          res_d   = prod;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      res_q    <= res_d;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign result_lo_o = res_q[size-1:0];
  assign result_hi_o = res_q[2*size-1:size];

endmodule

// File: tb/tb_iter_multiplier.sv
// Randomized and directed bench for iter_multiplier against a plain-arithmetic product model.
module tb_iter_multiplier;

  localparam int SIZE = 32;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            start_i = 1'b0;
  logic            signed_i = 1'b0;
  logic [SIZE-1:0] src1_i = '0;
  logic [SIZE-1:0] src2_i = '0;
  logic            busy_o, done_o;
  logic [SIZE-1:0] result_lo_o, result_hi_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [2*SIZE-1:0] exp_q[$];
  logic [2*SIZE-1:0] last_res = '0;

  iter_multiplier #(.size(SIZE)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .signed_i(signed_i),
    .src1_i(src1_i), .src2_i(src2_i), .busy_o(busy_o), .done_o(done_o),
    .result_lo_o(result_lo_o), .result_hi_o(result_hi_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint sa, sb;
    logic [63:0] ua, ub;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  function automatic int ref_latency(input logic [31:0] b, input bit sgn);
`ifdef EARLY_TERM_EN
    logic [31:0] m;
    int top;
    m = (sgn && b[31]) ? (~b + 32'd1) : b;
    top = 0;
    for (int i = 0; i < 32; i++) if (m[i]) top = i;
    return top + 1;
`else
    return SIZE;
`endif
  endfunction

  // Called one step after a rising edge with the DUT idle; returns in the first IDLE cycle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit sgn, input bit inject);
    int lat, busy_cnt, unstable, want_lat;
    bit seen;
    logic [63:0] exp_p;
    exp_q.push_back(ref_prod(a, b, sgn));
    want_lat = ref_latency(b, sgn);
    src1_i = a; src2_i = b; signed_i = sgn; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    src1_i = $urandom; src2_i = $urandom; signed_i = 1'($urandom_range(0, 1));
    busy_cnt = busy_o ? 1 : 0;
    lat = 0; seen = 0; unstable = 0;
    while (!seen && lat < 100) begin
      @(posedge clk_i); #1;
      lat++;
      if (busy_o) busy_cnt++;
      if (done_o) seen = 1;
      else if ({result_hi_o, result_lo_o} !== last_res) unstable++;
      start_i = 1'b0;
      if (inject && (lat == 9 || done_o)) begin
        start_i = 1'b1; src1_i = 32'd9; src2_i = 32'd9; signed_i = 1'b0;
      end
    end
    check_eq("done_seen", 64'(seen), 64'd1);
    check_eq("latency", 64'(lat), 64'(want_lat));
    check_eq("stable_in_calc", 64'(unstable), 64'd0);
    exp_p = exp_q.pop_front();
    check_eq("product", {result_hi_o, result_lo_o}, exp_p);
    last_res = exp_p;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check_eq("done_one_cycle", 64'(done_o), 64'd0);
    check_eq("busy_released", 64'(busy_o), 64'd0);
    check_eq("busy_cycles", 64'(busy_cnt), 64'(want_lat + 1));
    check_eq("result_hold", {result_hi_o, result_lo_o}, last_res);
  endtask

  initial begin
    #12;
    check_eq("reset_busy", 64'(busy_o), 64'd0);
    check_eq("reset_done", 64'(done_o), 64'd0);
    check_eq("reset_result", {result_hi_o, result_lo_o}, 64'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    do_op(32'd7, 32'd6, 1'b0, 1'b0);
    do_op(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    do_op(32'd3, 32'd4, 1'b0, 1'b1);
    do_op(32'd9, 32'd9, 1'b0, 1'b0);
    do_op(32'h1234_5678, 32'd1, 1'b0, 1'b0);
    do_op(32'h1234_5678, 32'h80, 1'b0, 1'b0);
    do_op(32'h1234_5678, 32'd0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a long operation.
    src1_i = 32'h1234_5678; src2_i = 32'hFFFF_FFFF; signed_i = 1'b0; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (15) @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    check_eq("rst_mid_busy", 64'(busy_o), 64'd0);
    check_eq("rst_mid_done", 64'(done_o), 64'd0);
    check_eq("rst_mid_result", {result_hi_o, result_lo_o}, 64'd0);
    last_res = '0;
    @(posedge clk_i); #2;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    do_op(32'd2, 32'd3, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'(1) << $urandom_range(0, 31);
        1: a = 32'h8000_0000;
        2: b = $urandom_range(0, 3);
        default: ;
      endcase
      do_op(a, b, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
